// File: rtl/alu_result_stage.sv
// -----------------------------------------------------------------------------
// alu_result_stage
//
// Output stage behind the adder. It buffers up to two {result, status} pairs in
// order, and it keeps a running OR of every accepted status word. It also
// counts, without wrapping, the accepted entries that have the overflow flag
// set. The data itself is passed through untouched.
//
// Ports
//   clk           single clock, rising edge
//   rst_n         asynchronous active-low reset; clears all stored entries
//   inValid       upstream presents result/statusIn this cycle
//   inReady       stage can accept an entry (occupancy < 2)
//   result        adder sum, WIDTH bits
//   statusIn      adder status flags, 4 bits
//   outValid      head entry available (occupancy > 0)
//   outReady      consumer takes the head entry this cycle
//   outResult     head entry result
//   outStatus     head entry status
//   stickyStatus  OR of all accepted status since the last clear
//   clrSticky     synchronous clear of stickyStatus and ovfCount
//   ovfCount      saturating count of accepted entries with overflow set
// -----------------------------------------------------------------------------
module alu_result_stage #(
    parameter int WIDTH       = 8,
    parameter int CNT_W       = 8,
    // Status bit layout shared with the adder. Only the overflow position
    // matters here; every other flag is handled as an opaque bit of the OR.
    parameter int ST_OVERFLOW = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] result,
    input  logic [3:0]       statusIn,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] outResult,
    output logic [3:0]       outStatus,
    output logic [3:0]       stickyStatus,
    input  logic             clrSticky,
    output logic [CNT_W-1:0] ovfCount
);

    // The head entry is held in its own register, so the outputs keep showing
    // the last popped entry when the stage drains. A second register holds
    // the tail entry. tail_vld_q implies head_vld_q.
    logic             head_vld_q, head_vld_d;
    logic [WIDTH-1:0] head_res_q, head_res_d;
    logic [3:0]       head_st_q,  head_st_d;
    logic             tail_vld_q, tail_vld_d;
    logic [WIDTH-1:0] tail_res_q, tail_res_d;
    logic [3:0]       tail_st_q,  tail_st_d;
    logic [3:0]       sticky_q,   sticky_d;
    logic [CNT_W-1:0] ovf_cnt_q,  ovf_cnt_d;

    logic push;
    logic pop;

    // Ready depends on registered occupancy only. It is gated by rst_n so that
    // it reads 0 while reset is held. There is no path from outReady, so a
    // full stage does not take a new entry in the same cycle as a pop.
    assign inReady  = rst_n & ~tail_vld_q;
    assign outValid = head_vld_q;

    assign push = inValid  & inReady;
    assign pop  = outValid & outReady;

    always_comb begin
        head_vld_d = head_vld_q;
        head_res_d = head_res_q;
        head_st_d  = head_st_q;
        tail_vld_d = tail_vld_q;
        tail_res_d = tail_res_q;
        tail_st_d  = tail_st_q;

        if (pop && tail_vld_q) begin
            // Full stage: the tail moves up. No push is possible here.
            head_res_d = tail_res_q;
            head_st_d  = tail_st_q;
            tail_vld_d = 1'b0;
        end else if (pop) begin
            // One entry: either replace it with the incoming entry, or go
            // empty and leave the data registers holding their last value.
            if (push) begin
                head_res_d = result;
                head_st_d  = statusIn;
            end else begin
                head_vld_d = 1'b0;
            end
        end else if (push) begin
            if (!head_vld_q) begin
                head_vld_d = 1'b1;
                head_res_d = result;
                head_st_d  = statusIn;
            end else begin
                tail_vld_d = 1'b1;
                tail_res_d = result;
                tail_st_d  = statusIn;
            end
        end
    end

    always_comb begin
        sticky_d  = sticky_q;
        ovf_cnt_d = ovf_cnt_q;

        // The clear applies first, so an entry accepted in the same cycle is
        // still counted against the freshly cleared state.
        if (clrSticky) begin
            sticky_d  = '0;
            ovf_cnt_d = '0;
        end

        if (push) begin
            sticky_d = sticky_d | statusIn;
            if (statusIn[ST_OVERFLOW] && (ovf_cnt_d != {CNT_W{1'b1}})) begin
                ovf_cnt_d = ovf_cnt_d + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_vld_q <= 1'b0;
            head_res_q <= '0;
            head_st_q  <= '0;
            tail_vld_q <= 1'b0;
            tail_res_q <= '0;
            tail_st_q  <= '0;
            sticky_q   <= '0;
            ovf_cnt_q  <= '0;
        end else begin
            head_vld_q <= head_vld_d;
            head_res_q <= head_res_d;
            head_st_q  <= head_st_d;
            tail_vld_q <= tail_vld_d;
            tail_res_q <= tail_res_d;
            tail_st_q  <= tail_st_d;
            sticky_q   <= sticky_d;
            ovf_cnt_q  <= ovf_cnt_d;
        end
    end

    assign outResult    = head_res_q;
    assign outStatus    = head_st_q;
    assign stickyStatus = sticky_q;
    assign ovfCount     = ovf_cnt_q;

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

    logic       clk;
    logic       rst_n;
    logic       inValid;
    logic       inReady;
    logic [7:0] result;
    logic [3:0] statusIn;
    logic       outValid;
    logic       outReady;
    logic [7:0] outResult;
    logic [3:0] outStatus;
    logic [3:0] stickyStatus;
    logic       clrSticky;
    logic [7:0] ovfCount;

    int errors = 0;
    int checks = 0;

    alu_result_stage #(.WIDTH(8), .CNT_W(8), .ST_OVERFLOW(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .inValid      (inValid),
        .inReady      (inReady),
        .result       (result),
        .statusIn     (statusIn),
        .outValid     (outValid),
        .outReady     (outReady),
        .outResult    (outResult),
        .outStatus    (outStatus),
        .stickyStatus (stickyStatus),
        .clrSticky    (clrSticky),
        .ovfCount     (ovfCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: an in-order queue of at most two entries, plus the
    // entry last shown at the head, plus the sticky OR and the overflow count.
    typedef struct {
        logic [7:0] r;
        logic [3:0] s;
    } ent_t;

    ent_t       mq[$];
    ent_t       m_last;
    logic [3:0] m_sticky;
    logic [7:0] m_ovf;

    typedef struct {
        logic       iv;
        logic [7:0] r;
        logic [3:0] s;
        logic       ordy;
        logic       clr;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_res;
        logic [3:0] e_st;
        logic [3:0] e_sticky;
        logic [7:0] e_ovf;
    } vec_t;

    vec_t tbl[10];

    function automatic logic [25:0] dut_vec();
        return {inReady, outValid, outResult, outStatus, stickyStatus, ovfCount};
    endfunction

    function automatic logic [25:0] model_vec();
        ent_t h;
        h = (mq.size() > 0) ? mq[0] : m_last;
        return {(mq.size() < 2) ? 1'b1 : 1'b0, (mq.size() > 0) ? 1'b1 : 1'b0,
                h.r, h.s, m_sticky, m_ovf};
    endfunction

    task automatic check(input string name, input logic [25:0] act, input logic [25:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_last   = '{8'h00, 4'h0};
        m_sticky = 4'h0;
        m_ovf    = 8'h00;
    endtask

    // Drives one cycle of inputs, advances the model across the edge, and
    // returns at posedge+1 so that outputs can be sampled away from the edge.
    task automatic step(input logic iv, input logic [7:0] r, input logic [3:0] s,
                        input logic ordy, input logic clr);
        bit pu, po;
        inValid   = iv;
        result    = r;
        statusIn  = s;
        outReady  = ordy;
        clrSticky = clr;
        pu = iv && (mq.size() < 2);
        po = ordy && (mq.size() > 0);
        @(posedge clk);
        if (po) m_last = mq.pop_front();
        if (pu) mq.push_back('{r, s});
        if (mq.size() > 0) m_last = mq[0];
        if (clr) begin
            m_sticky = 4'h0;
            m_ovf    = 8'h00;
        end
        if (pu) begin
            m_sticky = m_sticky | s;
            if (s[3] && m_ovf != 8'hFF) m_ovf = m_ovf + 8'd1;
        end
        #1;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        inValid   = 1'b0;
        result    = 8'h00;
        statusIn  = 4'h0;
        outReady  = 1'b0;
        clrSticky = 1'b0;
        model_reset();
        #12;
        check("reset_held", dut_vec(), 26'h0000000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle_after_reset", dut_vec(), 26'h2000000);
    endtask

    initial begin
        //          iv  r      s     ordy clr  ir ov res    st    sticky ovf
        tbl[0] = '{1'b1, 8'h00, 4'h3, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 4'h3, 4'h3, 8'h00};
        tbl[1] = '{1'b0, 8'h5A, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 4'h3, 4'h3, 8'h00};
        tbl[2] = '{1'b1, 8'h11, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 4'h0, 4'h3, 8'h00};
        tbl[3] = '{1'b1, 8'h22, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 4'h0, 4'h3, 8'h00};
        tbl[4] = '{1'b1, 8'h33, 4'h4, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 4'h0, 4'h3, 8'h00};
        tbl[5] = '{1'b1, 8'h33, 4'h4, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 4'h0, 4'h3, 8'h00};
        tbl[6] = '{1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h22, 4'h0, 4'h3, 8'h00};
        tbl[7] = '{1'b0, 8'h00, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h22, 4'h0, 4'h0, 8'h00};
        tbl[8] = '{1'b1, 8'h44, 4'h8, 1'b0, 1'b1, 1'b1, 1'b1, 8'h44, 4'h8, 4'h8, 8'h01};
        tbl[9] = '{1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h44, 4'h8, 4'h8, 8'h01};

        apply_reset();

        // Directed table: latency, backpressure, ignored third push, ordered
        // drain, clear alone, clear with push.
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].iv, tbl[i].r, tbl[i].s, tbl[i].ordy, tbl[i].clr);
            check($sformatf("table_row%0d", i), dut_vec(),
                  {tbl[i].e_ir, tbl[i].e_ov, tbl[i].e_res, tbl[i].e_st,
                   tbl[i].e_sticky, tbl[i].e_ovf});
        end

        // Counter saturation: 300 overflow pushes, streamed through at occupancy 1.
        step(1'b0, 8'h00, 4'h0, 1'b1, 1'b1);
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 8'($urandom), 4'h8, 1'b1, 1'b0);
            check("sat_model", dut_vec(), model_vec());
            if (i == 253) check("sat_cnt_fe", {18'd0, ovfCount}, {18'd0, 8'hFE});
            if (i == 254) check("sat_cnt_ff", {18'd0, ovfCount}, {18'd0, 8'hFF});
        end
        check("sat_cnt_hold", {17'd0, stickyStatus[3], ovfCount}, {17'd0, 1'b1, 8'hFF});
        step(1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
        check("sat_drain", dut_vec(), model_vec());

        // Clear coinciding with a push.
        step(1'b0, 8'h00, 4'h0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 4'h8, 1'b1, 1'b0);
        step(1'b1, 8'h66, 4'h4, 1'b1, 1'b0);
        check("pre_clr", {14'd0, stickyStatus, ovfCount}, {14'd0, 4'hC, 8'h05});
        step(1'b1, 8'h77, 4'h8, 1'b0, 1'b1);
        check("clr_with_push", {14'd0, stickyStatus, ovfCount}, {14'd0, 4'h8, 8'h01});
        check("clr_keeps_fifo", dut_vec(), model_vec());
        step(1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
        check("clr_drain", dut_vec(), model_vec());

        // Reset asserted between edges with two entries stored.
        step(1'b1, 8'hAA, 4'h1, 1'b0, 1'b0);
        step(1'b1, 8'hBB, 4'h2, 1'b0, 1'b0);
        check("full_before_rst", {24'd0, inReady, outValid}, {24'd0, 1'b0, 1'b1});
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst", dut_vec(), 26'h0000000);
        model_reset();
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
            check("post_rst_empty", dut_vec(), 26'h2000000);
        end
        step(1'b1, 8'hCC, 4'h0, 1'b0, 1'b0);
        check("post_rst_push", dut_vec(), model_vec());
        check("post_rst_head", {18'd0, outResult}, {18'd0, 8'hCC});

        // Randomized traffic against the model.
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 4'($urandom),
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0);
            check("random", dut_vec(), model_vec());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 The parameter WIDTH SHALL default to 8 and set the datapath width, matching the shared `WIDTH` in ALU_inc.v.
REQ-002 The parameter CNT_W SHALL default to 8 and set the width of the overflow event counter.
REQ-003 The block SHALL take status bit positions from the shared ST_CARRY, ST_ZERO, ST_NEG and ST_OVERFLOW indices in ALU_inc.v.
REQ-004 The block SHALL have the port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have the port rst_n, input, 1 bit, the reset, which is asynchronous and active-low.
REQ-006 The block SHALL have the port inValid, input, 1 bit, asserted when the adder result and status are presented.
REQ-007 The block SHALL have the port inReady, output, 1 bit, asserted when the stage can accept an entry.
REQ-008 The block SHALL have the port result, input, WIDTH bits, the adder sum.
REQ-009 The block SHALL have the port statusIn, input, 4 bits, the adder status flags.
REQ-010 The block SHALL have the port outValid, output, 1 bit, asserted when the head entry is available.
REQ-011 The block SHALL have the port outReady, input, 1 bit, asserted when the consumer takes the head entry.
REQ-012 The block SHALL have the port outResult, output, WIDTH bits, the head entry result.
REQ-013 The block SHALL have the port outStatus, output, 4 bits, the head entry status.
REQ-014 The block SHALL have the port stickyStatus, output, 4 bits, the OR of all accepted status since the last clear.
REQ-015 The block SHALL have the port clrSticky, input, 1 bit, a synchronous clear of stickyStatus and ovfCount.
REQ-016 The block SHALL have the port ovfCount, output, CNT_W bits, a saturating count of accepted entries with overflow set.

Function
REQ-017 Push SHALL occur on a clk edge where inValid and inReady are both 1; pop SHALL occur on a clk edge where outValid and outReady are both 1.
REQ-018 The stage SHALL be a 2-entry in-order FIFO; occupancy SHALL be 0, 1 or 2.
REQ-019 inReady SHALL be 1 exactly when occupancy is less than 2, computed from registered occupancy only, with no combinational path from outReady.
REQ-020 outValid SHALL be 1 exactly when occupancy is greater than 0; outResult and outStatus SHALL show the oldest entry and hold stable while outValid=1 and outReady=0.
REQ-021 An entry pushed into an empty stage at edge N SHALL appear on the outputs after edge N, giving 1-cycle latency with no combinational bypass.
REQ-022 A simultaneous push and pop at occupancy 1 SHALL leave occupancy at 1, with the new entry becoming head.
REQ-023 At occupancy 2, no push SHALL occur even if outReady=1 in the same cycle; a pop-only cycle SHALL take occupancy to 1.
REQ-024 A pop at occupancy 0 SHALL be impossible, and the outputs SHALL be held at their last values with outValid=0.
REQ-025 On push, stickyStatus SHALL become stickyStatus OR statusIn.
REQ-026 On push with statusIn[ST_OVERFLOW]=1, ovfCount SHALL increment by 1 and saturate at all-ones, never wrapping.
REQ-027 clrSticky=1 SHALL zero stickyStatus and ovfCount at the next edge.
REQ-028 When clrSticky=1 coincides with a push, the result SHALL be stickyStatus=statusIn and ovfCount=statusIn[ST_OVERFLOW]; the clear acts first and the new entry is still counted.
REQ-029 clrSticky SHALL NOT affect FIFO contents or occupancy.
REQ-030 Data values SHALL pass through unmodified; the block SHALL perform no arithmetic on result.

Reset
REQ-031 While rst_n=0, occupancy, outValid, outResult, outStatus, stickyStatus and ovfCount SHALL be 0.
REQ-032 While rst_n=0, inReady SHALL be 0.
REQ-033 Reset asserted mid-operation SHALL discard all stored entries immediately, without waiting for a clock edge.
REQ-034 The first push SHALL be possible on the first clk edge after rst_n deasserts.

Verification
REQ-035 The bench SHALL check post-reset idle behaviour: release rst_n -> inReady=1, outValid=0, ovfCount=0, stickyStatus=0.
REQ-036 The bench SHALL check single-entry latency: push result=8'h00 with ZERO|CARRY set, outReady=1 -> next cycle outValid=1, outResult=8'h00, then outValid=0 after the pop.
REQ-037 The bench SHALL check full/backpressure: outReady=0, push 8'h11 then 8'h22 -> inReady=0; a third inValid is ignored; raise outReady -> pops 8'h11 then 8'h22 in order.
REQ-038 The bench SHALL check counter saturation: push 300 entries with OVERFLOW set -> ovfCount=8'hFF and stays there; stickyStatus[ST_OVERFLOW]=1.
REQ-039 The bench SHALL check clear-with-push: ovfCount=5 and sticky NEG set; assert clrSticky with a push of OVERFLOW only -> ovfCount=1, stickyStatus has only OVERFLOW set.
REQ-040 The bench SHALL check reset mid-operation: occupancy 2, pull rst_n low between edges -> outValid=0 immediately; after release, the old entries never appear.
